muldiv_unit: RTL and testbench

Parametrised multi-cycle RV32M multiply/divide unit. It sits in the EX stage beside the single-cycle ALU and executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU with a valid/ready handshake on both sides. The datapath is an iterative shift-add multiplier and a restoring divider sharing one XLEN-cycle counter, with fast paths for divide-by-zero and signed overflow. The pipeline stalls on `in_ready`/`out_valid` and kills in-flight work with `flush`.

---
 rtl/muldiv_unit.sv | 141 ++++++++++++++
 tb/tb_muldiv_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider
// sharing one XLEN-cycle counter, with early-out for divide-by-zero and signed overflow.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [TAG_W-1:0]  tag_q, tag_d;

  logic              accept, a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag, special_res;
  logic [XLEN:0]     mul_sum, div_shift, div_trial;
  logic [2*XLEN-1:0] mul_next, div_next, acc_step, prod_fix;
  logic [XLEN-1:0]   div_mag, fin_res;

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign out_result = res_q;
  assign out_tag    = tag_q;
  assign accept     = in_valid && in_ready && !flush;

  // Operand decode and special-case detection on the incoming request
  always_comb begin
    a_signed    = (in_op == 3'd0) || (in_op == 3'd1) || (in_op == 3'd2) ||
                  (in_op == 3'd4) || (in_op == 3'd6);
    b_signed    = (in_op == 3'd0) || (in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6);
    a_neg       = a_signed && in_a[XLEN-1];
    b_neg       = b_signed && in_b[XLEN-1];
    a_mag       = a_neg ? -in_a : in_a;
    b_mag       = b_neg ? -in_b : in_b;
    div_zero    = in_op[2] && (in_b == '0);
    div_ovf     = in_op[2] && !in_op[0] && (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1);
    special_res = '0;
    if (div_zero)     special_res = in_op[1] ? in_a : '1;
    else if (div_ovf) special_res = in_op[1] ? '0 : in_a;
  end

  // One iteration step; acc holds {hi, lo} = {partial product, multiplier} or {remainder, quotient}
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? b_q : '0)};
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_trial = div_shift - {1'b0, b_q};
    div_next  = div_trial[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    acc_step  = op_q[2] ? div_next : mul_next;
    prod_fix  = neg_q ? -acc_step : acc_step;
    div_mag   = op_q[1] ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
    if (op_q[2])           fin_res = neg_q ? -div_mag : div_mag;
    else if (op_q == 3'd0) fin_res = prod_fix[XLEN-1:0];
    else                   fin_res = prod_fix[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    tag_d   = tag_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          op_d  = in_op;
          tag_d = in_tag;
          b_d   = b_mag;
          acc_d = {{XLEN{1'b0}}, a_mag};
          cnt_d = '0;
          // Remainder follows the dividend; quotient and product follow sign(a)^sign(b)
          neg_d = (in_op == 3'd6) ? a_neg : (a_neg ^ b_neg);
          if (div_zero || div_ovf) begin
            res_d   = special_res;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
        S_CALC: begin
          acc_d = acc_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN-1)) begin
            res_d   = fin_res;
            state_d = S_DONE;
          end
        end
        S_DONE: if (out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      tag_q   <= tag_d;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: result, tag and latency per op, plus
// backpressure, flush and asynchronous-reset sequences.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [2:0]  in_op = '0;
  logic [31:0] in_a = '0, in_b = '0, out_result;
  logic [4:0]  in_tag = '0, out_tag;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [4:0]  tag;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one request in IDLE; returns edges from accept (inclusive) until out_valid seen
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, output int lat);
    @(negedge clk);
    chk("pre_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  vec_t vecs[16];
  int   lat;
  bit   saw_valid;

  initial begin
    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 33};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000, 33};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, 33};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF, 33};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd7,  32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'd5, 32'd100,       32'd7,         5'd9,  32'd14,        33};
    vecs[7]  = '{3'd7, 32'd100,       32'd7,         5'd10, 32'd2,         33};
    vecs[8]  = '{3'd4, 32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd7, 32'd5,         32'd0,         5'd12, 32'd5,         1};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0,         1};
    vecs[12] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0,         33};
    vecs[13] = '{3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 33};
    vecs[14] = '{3'd0, 32'h1234_5678, 32'h0000_0010, 5'd31, 32'h2345_6780, 33};
    vecs[15] = '{3'd6, 32'd7,         32'd0,         5'd17, 32'd7,         1};

    // Reset state
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_tag", {27'd0, out_tag}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, lat);
      chk($sformatf("v%0d_result", i), out_result, vecs[i].exp);
      chk($sformatf("v%0d_tag", i), {27'd0, out_tag}, {27'd0, vecs[i].tag});
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      handshake();
    end

    // Backpressure: result and tag held, no new accept while DONE
    issue(3'd5, 32'd100, 32'd7, 5'd21, lat);
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_result", out_result, 32'd14);
      chk("bp_tag", {27'd0, out_tag}, 32'd21);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); @(negedge clk);
    end
    handshake();

    // Flush in IDLE blocks a simultaneous request
    in_valid = 1'b1; flush = 1'b1; in_op = 3'd0; in_a = 32'd9; in_b = 32'd9; in_tag = 5'd1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_idle_out_valid", {31'd0, out_valid}, 32'd0);

    // Flush at CALC cycle 10: killed op never produces a result
    in_valid = 1'b1; in_op = 3'd5; in_a = 32'd100; in_b = 32'd7; in_tag = 5'd2;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("calc_in_ready_low", {31'd0, in_ready}, 32'd0);
    repeat (9) begin @(posedge clk); @(negedge clk); end
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    chk("flush_calc_in_ready", {31'd0, in_ready}, 32'd1);
    saw_valid = 1'b0;
    repeat (40) begin @(posedge clk); @(negedge clk); if (out_valid) saw_valid = 1'b1; end
    chk("flush_no_result", {31'd0, saw_valid}, 32'd0);
    issue(3'd0, 32'd3, 32'd4, 5'd22, lat);
    chk("after_flush_mul", out_result, 32'd12);
    chk("after_flush_tag", {27'd0, out_tag}, 32'd22);
    chk("after_flush_lat", 32'(lat), 32'd33);

    // Flush wins over out_ready in DONE
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    chk("flush_done_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_done_in_ready", {31'd0, in_ready}, 32'd1);

    // Async reset mid-CALC, then in DONE: outputs clear without a clock edge
    in_valid = 1'b1; in_op = 3'd4; in_a = 32'd50; in_b = 32'd5; in_tag = 5'd3;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_calc_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_calc_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    issue(3'd4, 32'd5, 32'd0, 5'd9, lat);
    chk("pre_rst_done_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_done_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_done_result", out_result, 32'd0);
    chk("rst_done_tag", {27'd0, out_tag}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    issue(3'd7, 32'd100, 32'd7, 5'd30, lat);
    chk("post_rst_remu", out_result, 32'd2);
    chk("post_rst_lat", 32'(lat), 32'd33);
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
